// File: rtl/multiword_adder_pkg.sv
// multiword_adder shared types.
// FSM state encoding and index-width helper.
package multiword_adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Word index width: max(1, clog2(k)).
    function automatic int idx_width(input int k);
        return (k <= 2) ? 1 : $clog2(k);
    endfunction

    localparam int K_DEFAULT = 4;
    localparam int IDXW = idx_width(K_DEFAULT);

endpackage

// File: rtl/multiword_adder_ripple.sv
// multiword_adder word adder.
// Combinational N-bit ripple-carry adder.
module multiword_adder_ripple #(
    parameter int N = 8
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_cin,
    output logic [N-1:0] o_sum,
    output logic         o_cout
);

    logic [N:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar g = 0; g < N; g++) begin : g_bit
        assign o_sum[g]  = i_a[g] ^ i_b[g] ^ w_c[g];
        assign w_c[g+1]  = (i_a[g] & i_b[g])
                         | (w_c[g] & (i_a[g] ^ i_b[g]));
    end

    assign o_cout = w_c[N];

endmodule

// File: rtl/multiword_adder.sv
// multiword_adder top.
// W*K-bit add/sub, one W-bit word per cycle, LSW first.
module multiword_adder
    import multiword_adder_pkg::*;
#(
    parameter int W = 8,
    parameter int K = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W*K-1:0] a,
    input  logic [W*K-1:0] b,
    input  logic           cin,
    input  logic           sub,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W*K-1:0] s,
    output logic           cout,
    output logic           ovf
);

    localparam int IW = idx_width(K);

    state_t r_state;
    state_t w_next;

    logic [K-1:0][W-1:0] r_a;
    logic [K-1:0][W-1:0] r_b;
    logic [K-1:0][W-1:0] r_s;
    logic [IW-1:0]       r_idx;
    logic                r_carry;
    logic                r_cout;
    logic                r_ovf;

    logic [W-1:0] w_sum;
    logic         w_cout;
    logic         w_last;

    assign w_last = (r_idx == IW'(K - 1));

    multiword_adder_ripple #(
        .N(W)
    ) u_add (
        .i_a   (r_a[r_idx]),
        .i_b   (r_b[r_idx]),
        .i_cin (r_carry),
        .o_sum (w_sum),
        .o_cout(w_cout)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = RUN;
            end
            RUN: begin
                if (w_last) w_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Operand latch, per-word accumulate, final flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_carry <= sub ? 1'b1 : cin;
                        r_idx   <= '0;
                    end
                end
                RUN: begin
                    r_s[r_idx] <= w_sum;
                    r_carry    <= w_cout;
                    if (w_last) begin
                        r_idx  <= '0;
                        r_cout <= w_cout;
                        r_ovf  <= (r_a[K-1][W-1] == r_b[K-1][W-1])
                               && (w_sum[W-1] != r_a[K-1][W-1]);
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign s    = r_s;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_multiword_adder.sv
// multiword_adder bench.
// Directed vectors, hand-computed results.
module tb_multiword_adder;

    localparam int W = 8;
    localparam int K = 4;
    localparam int D = W * K;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [D-1:0] a;
    logic [D-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [D-1:0] s;
    logic         cout;
    logic         ovf;

    int checks   = 0;
    int failures = 0;

    multiword_adder #(
        .W(W),
        .K(K)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .s        (s),
        .cout     (cout),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_ready"}, 64'(in_ready), 64'd1);
    endtask

    task automatic wait_out(input string tag, output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "_ovalid"}, 64'(out_valid), 64'd1);
    endtask

    task automatic run_op(input string tag,
                          input logic [D-1:0] ta,
                          input logic [D-1:0] tb_,
                          input logic tsub,
                          input logic tcin,
                          input logic [D-1:0] es,
                          input logic ec,
                          input logic eo);
        int lat;
        wait_ready(tag);
        a        = ta;
        b        = tb_;
        sub      = tsub;
        cin      = tcin;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_out(tag, lat);
        chk({tag, "_lat"}, 64'(lat), 64'(K));
        chk({tag, "_s"}, 64'(s), 64'(es));
        chk({tag, "_cout"}, 64'(cout), 64'(ec));
        chk({tag, "_ovf"}, 64'(ovf), 64'(eo));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_drop"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        int lat;
        int n;
        int acc;
        logic pre;
        logic seen;
        logic [D-1:0] s1;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_s", 64'(s), 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);

        run_op("wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
               32'h0000_0000, 1'b1, 1'b0);
        run_op("sub57", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0,
               32'hFFFF_FFFE, 1'b0, 1'b0);
        run_op("sub75", 32'h0000_0007, 32'h0000_0005, 1'b1, 1'b0,
               32'h0000_0002, 1'b1, 1'b0);
        run_op("sovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
               32'h8000_0000, 1'b0, 1'b1);
        run_op("cin", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1,
               32'h2345_678A, 1'b0, 1'b0);

        // Backpressure, operand changes during RUN.
        wait_ready("bp");
        a        = 32'h0001_0002;
        b        = 32'h0003_0004;
        sub      = 1'b0;
        cin      = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a        = 32'hDEAD_BEEF;
        b        = 32'hCAFE_F00D;
        sub      = 1'b1;
        cin      = 1'b1;
        chk("bp_busy", 64'(in_ready), 64'd0);
        wait_out("bp", lat);
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold_v", 64'(out_valid), 64'd1);
            chk("bp_hold_s", 64'(s), 64'h0004_0006);
            chk("bp_hold_ir", 64'(in_ready), 64'd0);
            tick();
        end
        chk("bp_last_s", 64'(s), 64'h0004_0006);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_drop", 64'(out_valid), 64'd0);

        // Back-to-back with both handshakes held high.
        wait_ready("b2b");
        a         = 32'h0000_00FF;
        b         = 32'h0000_0001;
        sub       = 1'b0;
        cin       = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        a    = 32'h8000_0000;
        b    = 32'h0000_0001;
        sub  = 1'b1;
        acc  = 0;
        seen = 1'b0;
        s1   = '0;
        n    = 0;
        while (acc == 0 && n < 20) begin
            pre = in_ready;
            if (out_valid && !seen) begin
                seen = 1'b1;
                s1   = s;
            end
            tick();
            n++;
            if (pre) acc = n;
        end
        in_valid = 1'b0;
        chk("b2b_period", 64'(acc), 64'(K + 2));
        chk("b2b_s1", 64'(s1), 64'h0000_0100);
        wait_out("b2b2", lat);
        chk("b2b_lat2", 64'(lat), 64'(K));
        chk("b2b_s2", 64'(s), 64'h7FFF_FFFF);
        chk("b2b_c2", 64'(cout), 64'd1);
        chk("b2b_o2", 64'(ovf), 64'd1);
        tick();
        out_ready = 1'b0;
        chk("b2b_drop", 64'(out_valid), 64'd0);

        // Reset mid-RUN at idx=2.
        wait_ready("mrst");
        a        = 32'h0101_0101;
        b        = 32'h0202_0202;
        sub      = 1'b0;
        cin      = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_ir", 64'(in_ready), 64'd1);
        chk("mrst_ov", 64'(out_valid), 64'd0);
        chk("mrst_s", 64'(s), 64'd0);
        chk("mrst_c", 64'(cout), 64'd0);
        chk("mrst_o", 64'(ovf), 64'd0);
        run_op("post", 32'h0101_0101, 32'h0202_0202, 1'b0, 1'b0,
               32'h0303_0303, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
